// File: rtl/link_slave_rx_pkg.sv
// Shared types and widths for the receive side of the req/ack byte link.
//   BYTE_W      link byte width
//   ENTRY_W     receive FIFO entry width ({last, byte})
//   rx_state_t  handshake FSM states
//   rx_entry_t  FIFO payload: last-of-frame tag plus byte
package link_slave_rx_pkg;

  localparam int unsigned BYTE_W  = 8;
  localparam int unsigned ENTRY_W = BYTE_W + 1;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_DELAY,
    RX_ACK
  } rx_state_t;

  typedef struct packed {
    logic              last;
    logic [BYTE_W-1:0] data;
  } rx_entry_t;

endpackage

// File: rtl/link_slave_rx_if.sv
// Link-side and stream-side signals of the byte receiver.
//   req/data_in/ack                       4-phase byte handshake with the link master
//   out_valid/out_data/out_last/out_ready valid/ready stream towards the consumer
// slave: the receiver's view; master: the environment's view.
interface link_slave_rx_if;
  import link_slave_rx_pkg::*;

  logic              req;
  logic [BYTE_W-1:0] data_in;
  logic              ack;
  logic              out_valid;
  logic [BYTE_W-1:0] out_data;
  logic              out_last;
  logic              out_ready;

  modport slave (
    input  req, data_in, out_ready,
    output ack, out_valid, out_data, out_last
  );

  modport master (
    output req, data_in, out_ready,
    input  ack, out_valid, out_data, out_last
  );

endinterface

// File: rtl/link_slave_rx_fifo.sv
// Synchronous show-ahead FIFO buffering received link bytes.
//   clk, rst   clock, synchronous active-high reset (clears storage and pointers)
//   push, din  write request and data; ignored while full
//   pop        read request; ignored while empty
//   dout       current head entry (valid while !empty)
//   full/empty occupancy flags decoded from the registered count
module link_slave_rx_fifo #(
  parameter int unsigned WIDTH = 9,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic             do_push;
  logic             do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  assign full  = (count == CNT_W'(DEPTH));
  assign empty = (count == '0);
  assign dout  = mem[rd_ptr];

  // Storage, power-of-two pointers wrap naturally, occupancy count.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= wr_ptr + PTR_W'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/link_slave_rx.sv
// Receive side of the 4-phase req/ack byte link: captures one byte per
// handshake into a small FIFO, re-issues it on a valid/ready stream tagged
// with last-of-frame, and tracks frame position and per-frame XOR checksum.
//   clk, rst    clock, synchronous active-high reset
//   link        link_slave_rx_if.slave: req/data_in/ack and out_* stream
//   frame_done  one-cycle pulse after the last byte of a frame is captured
//   frame_csum  XOR of the most recently completed frame, held
//   byte_idx    bytes captured so far in the current frame
module link_slave_rx
  import link_slave_rx_pkg::*;
#(
  parameter  int unsigned FRAME_BYTES = 4,
  parameter  int unsigned FIFO_DEPTH  = 4,
  parameter  int unsigned ACK_DELAY   = 0,
  localparam int unsigned IDX_W       = $clog2(FRAME_BYTES) + 1
) (
  input  logic              clk,
  input  logic              rst,
  link_slave_rx_if.slave    link,
  output logic              frame_done,
  output logic [BYTE_W-1:0] frame_csum,
  output logic [IDX_W-1:0]  byte_idx
);

  localparam int unsigned DLY_W = 4;

  rx_state_t         state;
  logic              ack;
  logic [DLY_W-1:0]  dly;
  logic [BYTE_W-1:0] csum;
  logic              full;
  logic              empty;
  logic              capture;
  logic              pop;
  logic              is_last;
  rx_entry_t         push_entry;
  rx_entry_t         head;

  // A byte is taken only on leaving IDLE, so each handshake pushes once.
  assign capture    = (state == RX_IDLE) && link.req && !full;
  assign is_last    = (byte_idx == IDX_W'(FRAME_BYTES - 1));
  assign push_entry = '{last: is_last, data: link.data_in};
  assign pop        = !empty && link.out_ready;

  link_slave_rx_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (capture),
    .pop   (pop),
    .din   (push_entry),
    .dout  (head),
    .full  (full),
    .empty (empty)
  );

  assign link.ack       = ack;
  assign link.out_valid = !empty;
  assign link.out_data  = head.data;
  assign link.out_last  = head.last;

  // Handshake FSM with registered ack, optional pre-ack delay.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= RX_IDLE;
      ack   <= 1'b0;
      dly   <= '0;
    end else begin
      case (state)
        RX_IDLE: begin
          if (capture) begin
            if (ACK_DELAY > 0) begin
              state <= RX_DELAY;
              dly   <= DLY_W'(ACK_DELAY - 1);
            end else begin
              state <= RX_ACK;
              ack   <= 1'b1;
            end
          end
        end
        RX_DELAY: begin
          if (dly == '0) begin
            state <= RX_ACK;
            ack   <= 1'b1;
          end else begin
            dly <= dly - DLY_W'(1);
          end
        end
        RX_ACK: begin
          // A req that already fell (protocol violation) releases here too.
          if (!link.req) begin
            state <= RX_IDLE;
            ack   <= 1'b0;
          end
        end
        default: begin
          state <= RX_IDLE;
          ack   <= 1'b0;
        end
      endcase
    end
  end

  // Frame position, running checksum and completion pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      byte_idx   <= '0;
      csum       <= '0;
      frame_csum <= '0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= capture && is_last;
      if (capture) begin
        if (is_last) begin
          frame_csum <= csum ^ link.data_in;
          csum       <= '0;
          byte_idx   <= '0;
        end else begin
          csum     <= csum ^ link.data_in;
          byte_idx <= byte_idx + IDX_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_link_slave_rx.sv
module tb_link_slave_rx;

  logic       clk = 1'b0;
  logic       rst;
  logic       req;
  logic [7:0] data_in;
  logic       out_ready;

  logic       fd0, fd1, fd2;
  logic [7:0] cs0, cs1, cs2;
  logic [2:0] bi0, bi1, bi2;

  int n_cmp = 0;
  int n_bad = 0;

  logic [8:0] q0[$];
  logic [8:0] q1[$];
  logic [8:0] q2[$];
  int fdc0 = 0;
  int fdc1 = 0;
  int fdc2 = 0;

  always #5 clk = ~clk;

  link_slave_rx_if if0 ();
  link_slave_rx_if if1 ();
  link_slave_rx_if if2 ();

  assign if0.req = req;  assign if0.data_in = data_in;  assign if0.out_ready = out_ready;
  assign if1.req = req;  assign if1.data_in = data_in;  assign if1.out_ready = out_ready;
  assign if2.req = req;  assign if2.data_in = data_in;  assign if2.out_ready = out_ready;

  link_slave_rx #(.FRAME_BYTES(4), .FIFO_DEPTH(4), .ACK_DELAY(0)) u0 (
    .clk(clk), .rst(rst), .link(if0), .frame_done(fd0), .frame_csum(cs0), .byte_idx(bi0));
  link_slave_rx #(.FRAME_BYTES(4), .FIFO_DEPTH(2), .ACK_DELAY(0)) u1 (
    .clk(clk), .rst(rst), .link(if1), .frame_done(fd1), .frame_csum(cs1), .byte_idx(bi1));
  link_slave_rx #(.FRAME_BYTES(4), .FIFO_DEPTH(4), .ACK_DELAY(3)) u2 (
    .clk(clk), .rst(rst), .link(if2), .frame_done(fd2), .frame_csum(cs2), .byte_idx(bi2));

  // Stream monitor: inputs change at posedge+1, so negedge sees the values
  // that the next posedge acts on.
  always @(negedge clk) begin
    if (!rst) begin
      if (if0.out_valid && if0.out_ready) q0.push_back({if0.out_last, if0.out_data});
      if (if1.out_valid && if1.out_ready) q1.push_back({if1.out_last, if1.out_data});
      if (if2.out_valid && if2.out_ready) q2.push_back({if2.out_last, if2.out_data});
      if (fd0) fdc0++;
      if (fd1) fdc1++;
      if (fd2) fdc2++;
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  function automatic logic get_ack(input int sel);
    case (sel)
      0:       return if0.ack;
      1:       return if1.ack;
      default: return if2.ack;
    endcase
  endfunction

  function automatic logic [8:0] q_at(input int sel, input int idx);
    case (sel)
      0:       return (idx < q0.size()) ? q0[idx] : 9'bx;
      1:       return (idx < q1.size()) ? q1[idx] : 9'bx;
      default: return (idx < q2.size()) ? q2[idx] : 9'bx;
    endcase
  endfunction

  task automatic do_reset();
    rst = 1'b1; req = 1'b0; data_in = 8'h00; out_ready = 1'b0;
    cyc(); cyc();
    rst = 1'b0;
  endtask

  // Full 4-phase handshake of one byte against DUT sel, bounded waits.
  task automatic send(input int sel, input logic [7:0] b);
    logic got;
    req = 1'b1; data_in = b; got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      cyc();
      if (get_ack(sel) === 1'b1) got = 1'b1;
    end
    req = 1'b0;
    n_cmp++;
    if (got !== 1'b1) begin n_bad++; $display("FAIL send_ack dut%0d byte %h: ack never rose", sel, b); end
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      cyc();
      if (get_ack(sel) === 1'b0) got = 1'b1;
    end
    n_cmp++;
    if (got !== 1'b1) begin n_bad++; $display("FAIL send_release dut%0d byte %h: ack never fell", sel, b); end
  endtask

  task automatic test_reset();
    do_reset();
    n_cmp++; if (if0.ack !== 1'b0) begin n_bad++; $display("FAIL rst_ack got %b want 0", if0.ack); end
    n_cmp++; if (if0.out_valid !== 1'b0) begin n_bad++; $display("FAIL rst_valid got %b want 0", if0.out_valid); end
    n_cmp++; if (if0.out_data !== 8'h00) begin n_bad++; $display("FAIL rst_data got %h want 00", if0.out_data); end
    n_cmp++; if (if0.out_last !== 1'b0) begin n_bad++; $display("FAIL rst_last got %b want 0", if0.out_last); end
    n_cmp++; if (fd0 !== 1'b0) begin n_bad++; $display("FAIL rst_fdone got %b want 0", fd0); end
    n_cmp++; if (cs0 !== 8'h00) begin n_bad++; $display("FAIL rst_csum got %h want 00", cs0); end
    n_cmp++; if (bi0 !== 3'd0) begin n_bad++; $display("FAIL rst_idx got %0d want 0", bi0); end
  endtask

  task automatic test_frame();
    logic [8:0] exp [4] = '{9'h0A1, 9'h0B2, 9'h0C3, 9'h1D4};
    int b = q0.size();
    int f = fdc0;
    out_ready = 1'b1;
    send(0, 8'hA1); send(0, 8'hB2); send(0, 8'hC3); send(0, 8'hD4);
    cyc(); cyc(); cyc();
    n_cmp++; if (q0.size() - b !== 4) begin n_bad++; $display("FAIL frame_count got %0d want 4", q0.size() - b); end
    for (int i = 0; i < 4; i++) begin
      n_cmp++;
      if (q_at(0, b + i) !== exp[i]) begin n_bad++; $display("FAIL frame_out[%0d] got %h want %h", i, q_at(0, b + i), exp[i]); end
    end
    n_cmp++; if (fdc0 - f !== 1) begin n_bad++; $display("FAIL frame_pulses got %0d want 1", fdc0 - f); end
    n_cmp++; if (cs0 !== 8'h04) begin n_bad++; $display("FAIL frame_csum got %h want 04", cs0); end
    n_cmp++; if (bi0 !== 3'd0) begin n_bad++; $display("FAIL frame_idx_wrap got %0d want 0", bi0); end
    n_cmp++; if (if0.out_valid !== 1'b0) begin n_bad++; $display("FAIL frame_drained got %b want 0", if0.out_valid); end
  endtask

  // Runs straight after test_frame so frame_csum starts at 04.
  task automatic test_mid_reset();
    int b;
    out_ready = 1'b0;
    send(0, 8'hA1);
    req = 1'b1; data_in = 8'hB2;
    cyc();
    n_cmp++; if (if0.ack !== 1'b1) begin n_bad++; $display("FAIL mrst_in_ack got %b want 1", if0.ack); end
    rst = 1'b1;
    cyc();
    n_cmp++; if (if0.ack !== 1'b0) begin n_bad++; $display("FAIL mrst_ack got %b want 0", if0.ack); end
    n_cmp++; if (if0.out_valid !== 1'b0) begin n_bad++; $display("FAIL mrst_valid got %b want 0", if0.out_valid); end
    n_cmp++; if (bi0 !== 3'd0) begin n_bad++; $display("FAIL mrst_idx got %0d want 0", bi0); end
    n_cmp++; if (cs0 !== 8'h00) begin n_bad++; $display("FAIL mrst_csum got %h want 00", cs0); end
    rst = 1'b0; req = 1'b0;
    cyc();
    b = q0.size();
    out_ready = 1'b1;
    send(0, 8'hA1);
    cyc(); cyc();
    n_cmp++; if (bi0 !== 3'd1) begin n_bad++; $display("FAIL mrst_fresh_idx got %0d want 1", bi0); end
    n_cmp++; if (q0.size() - b !== 1) begin n_bad++; $display("FAIL mrst_fresh_count got %0d want 1", q0.size() - b); end
    n_cmp++; if (q_at(0, b) !== 9'h0A1) begin n_bad++; $display("FAIL mrst_fresh_byte got %h want 0a1", q_at(0, b)); end
  endtask

  task automatic test_backpressure();
    logic [8:0] exp [3] = '{9'h0A1, 9'h0B2, 9'h0C3};
    int b;
    do_reset();
    b = q1.size();
    send(1, 8'hA1); send(1, 8'hB2);
    req = 1'b1; data_in = 8'hC3;
    for (int i = 0; i < 3; i++) begin
      cyc();
      n_cmp++; if (if1.ack !== 1'b0) begin n_bad++; $display("FAIL bp_hold_ack[%0d] got %b want 0", i, if1.ack); end
    end
    n_cmp++; if (if1.out_data !== 8'hA1) begin n_bad++; $display("FAIL bp_head got %h want a1", if1.out_data); end
    out_ready = 1'b1;
    cyc();
    n_cmp++; if (if1.ack !== 1'b0) begin n_bad++; $display("FAIL bp_pop_cycle_ack got %b want 0", if1.ack); end
    n_cmp++; if (if1.out_data !== 8'hB2) begin n_bad++; $display("FAIL bp_head2 got %h want b2", if1.out_data); end
    cyc();
    n_cmp++; if (if1.ack !== 1'b1) begin n_bad++; $display("FAIL bp_capture_ack got %b want 1", if1.ack); end
    req = 1'b0;
    cyc(); cyc(); cyc();
    n_cmp++; if (q1.size() - b !== 3) begin n_bad++; $display("FAIL bp_count got %0d want 3", q1.size() - b); end
    for (int i = 0; i < 3; i++) begin
      n_cmp++;
      if (q_at(1, b + i) !== exp[i]) begin n_bad++; $display("FAIL bp_out[%0d] got %h want %h", i, q_at(1, b + i), exp[i]); end
    end
    n_cmp++; if (bi1 !== 3'd3) begin n_bad++; $display("FAIL bp_idx got %0d want 3", bi1); end
  endtask

  task automatic test_ack_delay();
    logic [8:0] exp [4] = '{9'h0A1, 9'h0B2, 9'h0C3, 9'h1D4};
    logic got;
    int b, f;
    do_reset();
    b = q2.size(); f = fdc2;
    out_ready = 1'b1;
    req = 1'b1; data_in = 8'hA1;
    for (int k = 1; k <= 4; k++) begin
      cyc();
      n_cmp++;
      if (if2.ack !== (k == 4)) begin n_bad++; $display("FAIL dly_ack_cycle%0d got %b want %b", k, if2.ack, (k == 4)); end
    end
    req = 1'b0; got = 1'b0;
    for (int i = 0; i < 10 && !got; i++) begin
      cyc();
      if (if2.ack === 1'b0) got = 1'b1;
    end
    n_cmp++; if (got !== 1'b1) begin n_bad++; $display("FAIL dly_release: ack stuck high"); end
    send(2, 8'hB2); send(2, 8'hC3); send(2, 8'hD4);
    cyc(); cyc(); cyc();
    n_cmp++; if (q2.size() - b !== 4) begin n_bad++; $display("FAIL dly_count got %0d want 4", q2.size() - b); end
    for (int i = 0; i < 4; i++) begin
      n_cmp++;
      if (q_at(2, b + i) !== exp[i]) begin n_bad++; $display("FAIL dly_out[%0d] got %h want %h", i, q_at(2, b + i), exp[i]); end
    end
    n_cmp++; if (fdc2 - f !== 1) begin n_bad++; $display("FAIL dly_pulses got %0d want 1", fdc2 - f); end
    n_cmp++; if (cs2 !== 8'h04) begin n_bad++; $display("FAIL dly_csum got %h want 04", cs2); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] pat [12] = '{8'hA1, 8'hB2, 8'hC3, 8'hD4, 8'hA1, 8'hB2,
                             8'hC3, 8'hD4, 8'hA1, 8'hB2, 8'hC3, 8'hD4};
    logic [8:0] e;
    int b, f;
    do_reset();
    b = q0.size(); f = fdc0;
    send(0, pat[0]); send(0, pat[1]); send(0, pat[2]);
    for (int i = 3; i < 12; i++) begin
      req = 1'b1; data_in = pat[i]; out_ready = 1'b1;
      cyc();
      out_ready = 1'b0; req = 1'b0;
      n_cmp++; if (if0.ack !== 1'b1) begin n_bad++; $display("FAIL b2b_ack[%0d] got %b want 1", i, if0.ack); end
      n_cmp++; if (u0.u_fifo.count !== 3'd3) begin n_bad++; $display("FAIL b2b_count[%0d] got %0d want 3", i, u0.u_fifo.count); end
      cyc();
    end
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) cyc();
    n_cmp++; if (q0.size() - b !== 12) begin n_bad++; $display("FAIL b2b_total got %0d want 12", q0.size() - b); end
    for (int i = 0; i < 12; i++) begin
      e = {(i % 4 == 3), pat[i]};
      n_cmp++;
      if (q_at(0, b + i) !== e) begin n_bad++; $display("FAIL b2b_out[%0d] got %h want %h", i, q_at(0, b + i), e); end
    end
    n_cmp++; if (fdc0 - f !== 3) begin n_bad++; $display("FAIL b2b_pulses got %0d want 3", fdc0 - f); end
    n_cmp++; if (cs0 !== 8'h04) begin n_bad++; $display("FAIL b2b_csum got %h want 04", cs0); end
    n_cmp++; if (bi0 !== 3'd0) begin n_bad++; $display("FAIL b2b_idx got %0d want 0", bi0); end
  endtask

  // req high for a single cycle on the delayed-ack receiver.
  task automatic test_req_pulse();
    int b;
    do_reset();
    b = q2.size();
    out_ready = 1'b1;
    req = 1'b1; data_in = 8'h5A;
    cyc();
    req = 1'b0;
    n_cmp++; if (bi2 !== 3'd1) begin n_bad++; $display("FAIL pulse_captured got %0d want 1", bi2); end
    for (int k = 2; k <= 5; k++) begin
      cyc();
      n_cmp++;
      if (if2.ack !== (k == 4)) begin n_bad++; $display("FAIL pulse_ack_cycle%0d got %b want %b", k, if2.ack, (k == 4)); end
    end
    cyc(); cyc(); cyc();
    n_cmp++; if (if2.ack !== 1'b0) begin n_bad++; $display("FAIL pulse_ack_stays_low got %b want 0", if2.ack); end
    n_cmp++; if (bi2 !== 3'd1) begin n_bad++; $display("FAIL pulse_single_capture got %0d want 1", bi2); end
    n_cmp++; if (q2.size() - b !== 1) begin n_bad++; $display("FAIL pulse_count got %0d want 1", q2.size() - b); end
    n_cmp++; if (q_at(2, b) !== 9'h05A) begin n_bad++; $display("FAIL pulse_byte got %h want 05a", q_at(2, b)); end
  endtask

  initial begin
    test_reset();
    test_frame();
    test_mid_reset();
    test_backpressure();
    test_ack_delay();
    test_back_to_back();
    test_req_pulse();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
